// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the parameterised data memory.
// The FSM encoding and default sizing constants live here.
package dmem_pkg;

    localparam int DEF_DATA_W   = 32'd8;
    localparam int DEF_ADDR_W   = 32'd32;
    localparam int DEF_DEPTH    = 32'd256;
    localparam int DEF_READ_LAT = 32'd1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Un-reset storage array: one synchronous write port and one combinational read port.
// Write-first behaviour comes from the read pipeline in the top sampling after the write edge.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_memory_param.sv
// Parameterised data memory with active-low enables, range checking, a pipelined
// read path of READ_LAT cycles and a one-word-per-cycle zeroing sweep.
module data_memory_param
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_WE,
    input  logic              mem_RE,
    input  logic [DATA_W-1:0] Data,
    input  logic [ADDR_W-1:0] Dir,
    input  logic              clear_start,
    output logic [DATA_W-1:0] Data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    dmem_state_e       state_r;
    dmem_state_e       state_nxt_s;
    logic [IDX_W-1:0]  clr_cnt_r;
    logic              idle_s;
    logic              oor_s;
    logic              rd_acc_s;
    logic              wr_req_s;
    logic              wr_acc_s;
    logic              clr_acc_s;
    logic              arr_we_s;
    logic [IDX_W-1:0]  arr_waddr_s;
    logic [DATA_W-1:0] arr_wdata_s;
    logic [DATA_W-1:0] arr_rdata_s;
    logic              s1_valid_r;
    logic [IDX_W-1:0]  s1_idx_r;
    logic              s1_oor_r;
    logic [DATA_W-1:0] rd_word_s;
    logic              out_valid_s;
    logic [DATA_W-1:0] out_data_s;

    assign idle_s    = (state_r == IDLE);
    assign oor_s     = ({1'b0, Dir} >= DEPTH_EXT);
    assign rd_acc_s  = idle_s & ~mem_RE;
    assign wr_req_s  = idle_s & ~mem_WE;
    assign wr_acc_s  = wr_req_s & ~oor_s;
    assign clr_acc_s = idle_s & clear_start;
    assign busy      = ~idle_s;

    // Next-state logic for the clear sweep FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (clear_start) state_nxt_s = CLEAR;
                else             state_nxt_s = IDLE;
            end
            CLEAR: begin
                if (clr_cnt_r == LAST_IDX) state_nxt_s = IDLE;
                else                       state_nxt_s = CLEAR;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state and sweep address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            clr_cnt_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == CLEAR && clr_cnt_r != LAST_IDX) clr_cnt_r <= clr_cnt_r + 1'b1;
            else                                           clr_cnt_r <= {IDX_W{1'b0}};
        end
    end

    // The sweep owns the write port while busy; user writes are dropped then.
    always_comb begin
        arr_we_s    = 1'b0;
        arr_waddr_s = {IDX_W{1'b0}};
        arr_wdata_s = {DATA_W{1'b0}};
        if (state_r == CLEAR) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = clr_cnt_r;
            arr_wdata_s = {DATA_W{1'b0}};
        end else begin
            arr_we_s    = wr_acc_s;
            arr_waddr_s = Dir[IDX_W-1:0];
            arr_wdata_s = Data;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (arr_we_s),
        .wr_addr (arr_waddr_s),
        .wr_data (arr_wdata_s),
        .rd_addr (s1_idx_r),
        .rd_data (arr_rdata_s)
    );

    // Sticky range error; an accepted clear wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 addr_err <= 1'b0;
        else if (clr_acc_s)                         addr_err <= 1'b0;
        else if ((rd_acc_s | wr_req_s) & oor_s)     addr_err <= 1'b1;
        else                                        addr_err <= addr_err;
    end

    // Read acceptance stage; the array is read one edge later so same-edge writes are seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= {IDX_W{1'b0}};
            s1_oor_r   <= 1'b0;
        end else begin
            s1_valid_r <= rd_acc_s;
            s1_idx_r   <= Dir[IDX_W-1:0];
            s1_oor_r   <= oor_s;
        end
    end

    assign rd_word_s = s1_oor_r ? {DATA_W{1'b0}} : arr_rdata_s;

    if (READ_LAT == 2) begin : g_lat2
        logic              s2_valid_r;
        logic [DATA_W-1:0] s2_data_r;

        // Second stage snapshots the array before any later write can land.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_r <= 1'b0;
                s2_data_r  <= {DATA_W{1'b0}};
            end else begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) s2_data_r <= rd_word_s;
            end
        end

        assign out_valid_s = s2_valid_r;
        assign out_data_s  = s2_data_r;
    end else begin : g_lat1
        assign out_valid_s = s1_valid_r;
        assign out_data_s  = rd_word_s;
    end

    // Registered read outputs; Data_out holds between completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            Data_out <= {DATA_W{1'b0}};
        end else begin
            rd_valid <= out_valid_s;
            if (out_valid_s) Data_out <= out_data_s;
        end
    end

endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench: one READ_LAT=1 and one READ_LAT=2 instance driven in lockstep;
// expected reads are queued at issue and popped by per-instance monitors on rd_valid.
module tb_data_memory_param;

    localparam int DEPTH = 32;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_WE;
    logic        mem_RE;
    logic [7:0]  Data;
    logic [31:0] Dir;
    logic        clear_start;
    logic [7:0]  d1, d2;
    logic        v1, v2, b1, b2, e1, e2;

    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       m1, m2;
    logic [7:0] model [DEPTH];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         exp_busy = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_memory_param #(.DATA_W(8), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .mem_WE(mem_WE), .mem_RE(mem_RE), .Data(Data), .Dir(Dir),
        .clear_start(clear_start), .Data_out(d1), .rd_valid(v1), .busy(b1), .addr_err(e1)
    );

    data_memory_param #(.DATA_W(8), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .mem_WE(mem_WE), .mem_RE(mem_RE), .Data(Data), .Dir(Dir),
        .clear_start(clear_start), .Data_out(d2), .rd_valid(v2), .busy(b2), .addr_err(e2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per rd_valid and check data and completion edge.
    always @(posedge clk) begin
        #1;
        if (v1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat1_unexpected_valid: got rd_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                m1 = q1.pop_front();
                chk("lat1_data", {24'h0, d1}, {24'h0, m1.data});
                chk("lat1_latency", cyc, m1.due);
            end
        end
        if (v2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat2_unexpected_valid: got rd_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                m2 = q2.pop_front();
                chk("lat2_data", {24'h0, d2}, {24'h0, m2.data});
                chk("lat2_latency", cyc, m2.due);
            end
        end
    end

    task automatic op(input bit wr, input bit rd, input logic [7:0] data,
                      input logic [31:0] dir, input bit clr);
        exp_t e;
        @(negedge clk);
        mem_WE      = ~wr;
        mem_RE      = ~rd;
        Data        = data;
        Dir         = dir;
        clear_start = clr;
        if (!exp_busy) begin
            if (wr && dir < DEPTH) model[dir[4:0]] = data;
            if (rd) begin
                e.data = (dir < DEPTH) ? model[dir[4:0]] : 8'h00;
                e.due  = cyc + 1 + 1;
                q1.push_back(e);
                e.due  = cyc + 1 + 2;
                q2.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) op(1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
    endtask

    task automatic chk_flags(input string name, input logic bsy, input logic err);
        chk({name, "_busy1"}, {31'h0, b1}, {31'h0, bsy});
        chk({name, "_busy2"}, {31'h0, b2}, {31'h0, bsy});
        chk({name, "_err1"}, {31'h0, e1}, {31'h0, err});
        chk({name, "_err2"}, {31'h0, e2}, {31'h0, err});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mem_WE = 1'b1; mem_RE = 1'b1; Data = 8'h00; Dir = 32'd0; clear_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_flags("reset", 1'b0, 1'b0);
        chk("reset_dout1", {24'h0, d1}, 32'h0);
        chk("reset_dout2", {24'h0, d2}, 32'h0);
        chk("reset_valid1", {31'h0, v1}, 32'h0);
        chk("reset_valid2", {31'h0, v2}, 32'h0);
        rst_n = 1'b1;

        // Basic write then read.
        op(1'b1, 1'b0, 8'hA5, 32'd3, 1'b0);
        op(1'b0, 1'b1, 8'h00, 32'd3, 1'b0);
        idle(3);
        chk_flags("basic", 1'b0, 1'b0);

        // Same-edge write/read returns new data; output then holds.
        op(1'b1, 1'b1, 8'h3C, 32'd7, 1'b0);
        idle(4);
        chk("hold1", {24'h0, d1}, 32'h3C);
        chk("hold2", {24'h0, d2}, 32'h3C);

        // Writes after the acceptance edge are not returned.
        op(1'b1, 1'b0, 8'h11, 32'd5, 1'b0);
        op(1'b0, 1'b1, 8'h00, 32'd5, 1'b0);
        op(1'b1, 1'b0, 8'h22, 32'd5, 1'b0);
        op(1'b1, 1'b0, 8'h33, 32'd5, 1'b0);
        op(1'b0, 1'b1, 8'h00, 32'd5, 1'b0);
        idle(3);

        // Out-of-range accesses.
        op(1'b1, 1'b0, 8'h11, 32'd0, 1'b0);
        op(1'b1, 1'b0, 8'h99, DEPTH, 1'b0);
        idle(1);
        chk_flags("oor_wr", 1'b0, 1'b1);
        op(1'b0, 1'b1, 8'h00, 32'd0, 1'b0);
        op(1'b0, 1'b1, 8'h00, DEPTH, 1'b0);
        op(1'b1, 1'b1, 8'h77, 32'h8000_0003, 1'b0);
        op(1'b0, 1'b1, 8'h00, 32'd3, 1'b0);
        idle(3);
        chk_flags("oor_rd", 1'b0, 1'b1);

        // Fill, then clear with a same-edge read; everything is ignored while busy.
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'hFF, i, 1'b0);
        op(1'b0, 1'b1, 8'h00, 32'd0, 1'b1);
        exp_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b1, 1'b1, 8'h55, i, (i == 5));
            chk("sweep_busy1", {31'h0, b1}, 32'h1);
            chk("sweep_busy2", {31'h0, b2}, 32'h1);
        end
        exp_busy = 1'b0;
        idle(1);
        chk_flags("sweep_done", 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00, i, 1'b0);
        idle(3);

        // Back-to-back reads.
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i * 7 + 1), i, 1'b0);
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 8'h00, i, 1'b0);
        idle(4);

        // Reset in the middle of a sweep after addresses 0..9 were cleared.
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'hFF, i, 1'b0);
        op(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
        exp_busy = 1'b1;
        idle(11);
        rst_n = 1'b0;
        #1;
        chk_flags("abort", 1'b0, 1'b0);
        chk("abort_dout1", {24'h0, d1}, 32'h0);
        chk("abort_dout2", {24'h0, d2}, 32'h0);
        q1.delete();
        q2.delete();
        exp_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = (i < 10) ? 8'h00 : 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00, i, 1'b0);
        idle(4);

        chk("drain_q1", q1.size(), 32'd0);
        chk("drain_q2", q2.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, width of address port Dir.
REQ-003 SHALL have parameter DEPTH, default 256, number of words; valid range 2..2^16.
REQ-004 SHALL have parameter READ_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mem_WE  input  1  write enable, active-low.
REQ-008 SHALL have port mem_RE  input  1  read enable, active-low.
REQ-009 SHALL have port Data  input  DATA_W  write data.
REQ-010 SHALL have port Dir  input  ADDR_W  word address.
REQ-011 SHALL have port clear_start  input  1  one-cycle pulse that starts a full-memory zeroing sweep.
REQ-012 SHALL have port Data_out  output  DATA_W  read data, held until the next read completes.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse marking new Data_out.
REQ-014 SHALL have port busy  output  1  high while a clear sweep runs.
REQ-015 SHALL have port addr_err  output  1  sticky flag, set by any access with Dir >= DEPTH.

Function
REQ-016 SHALL sample a write when mem_WE=0, busy=0, Dir<DEPTH at a rising edge and store Data at Dir on that edge.
REQ-017 SHALL accept a read when mem_RE=0 and busy=0; Data_out and rd_valid update exactly READ_LAT rising edges later.
REQ-018 SHALL issue one read per cycle with mem_RE held low, fully pipelined, one rd_valid per accepted read.
REQ-019 SHALL, when a read and a write target the same address on the same edge, return the new Data (write-first).
REQ-020 SHALL, for READ_LAT=2, return a write landing between read acceptance and completion only if that write occurred on the acceptance edge.
REQ-021 SHALL suppress writes with Dir>=DEPTH, return 0 with rd_valid for reads with Dir>=DEPTH, and set addr_err on the same edge.
REQ-022 SHALL keep addr_err set until reset or an accepted clear_start.
REQ-023 SHALL implement FSM IDLE->CLEAR when clear_start=1 in IDLE; CLEAR->IDLE after address DEPTH-1 is written.
REQ-024 SHALL, in CLEAR, write 0 to one address per cycle from 0 upward; sweep takes exactly DEPTH cycles; busy=1 throughout.
REQ-025 SHALL, while busy=1, ignore mem_WE, mem_RE and clear_start; no rd_valid for ignored reads.
REQ-026 SHALL still deliver reads accepted before clear_start; clear_start and read on the same edge: read accepted first, clear begins that edge.
REQ-027 SHALL hold Data_out unchanged when no read completes.

Reset
REQ-028 SHALL on rst_n=0 immediately force Data_out=0, rd_valid=0, busy=0, addr_err=0, FSM=IDLE, sweep counter=0, read pipeline empty.
REQ-029 SHALL NOT reset memory contents; clearing is done only by the sweep.
REQ-030 SHALL abort a sweep on reset mid-operation; untouched words keep old values.
REQ-031 SHALL discard in-flight reads on reset; no rd_valid after reset release until a new read is accepted.

Structure
REQ-032 SHALL place FSM state enum (IDLE, CLEAR) and default parameter constants in shared package dmem_pkg.
REQ-033 SHALL place the storage array, with no reset and one synchronous write and one read port, in sub-module dmem_array; the FSM, range checks and read pipeline stay in the top.

Verification
REQ-034 SHALL cover write 8'hA5 at Dir=3, then read Dir=3 -> Data_out=8'hA5, rd_valid pulse READ_LAT cycles later, addr_err=0.
REQ-035 SHALL cover same-edge write 8'h3C and read at Dir=7 -> Data_out=8'h3C.
REQ-036 SHALL cover write at Dir=DEPTH -> no word changes, addr_err=1; read Dir=DEPTH -> Data_out=0 with rd_valid, addr_err stays 1.
REQ-037 SHALL cover fill all words with 8'hFF, pulse clear_start -> busy exactly DEPTH cycles; reads during busy give no rd_valid; afterwards every address reads 0 and addr_err=0.
REQ-038 SHALL cover reset at sweep cycle 10 -> busy=0 immediately; addresses 0..9 read 0, 10..DEPTH-1 read 8'hFF.
REQ-039 SHALL cover back-to-back reads of Dir 0..15 with READ_LAT=2 -> 16 consecutive rd_valid pulses, data in order.
